// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between the fetch
// stage (reads only) and the memory stage (reads/writes). Data has priority
// over fetch, and a starvation guard hands the port to fetch after STARVE_MAX
// consecutive data wins. A write-back cancel squashes fetch issue and drops
// an in-flight fetch response.
// Optional build macro: ARB_STALL_CNT_EN enables the 32-bit fetch stall counter;
// without it stall_cnt is tied to zero.
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_ack,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,
    input  logic              cancel,
    output logic              mem_en,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       stall_cnt
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    // Owner of the access whose SRAM data returns this cycle
    typedef enum logic [1:0] {NONE, OWN_I, OWN_D} own_t;

    own_t              state, state_nxt;
    logic [3:0]        starve_cnt, starve_nxt;
    logic [DATA_W-1:0] inst_hold, data_hold;

    // Owner register and starvation counter; reset discards any in-flight response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= NONE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Grant arbitration, next owner and starvation count update
    always_comb begin
        inst_gnt   = 1'b0;
        data_gnt   = 1'b0;
        state_nxt  = NONE;
        starve_nxt = starve_cnt;
        // gating with resetn keeps grants low for the whole reset, not just after an edge
        if (resetn) begin
            if (inst_req && !cancel && (!data_req || starve_cnt == SMAX))
                inst_gnt = 1'b1;
            else if (data_req)
                data_gnt = 1'b1;
        end
        if (inst_gnt)
            state_nxt = OWN_I;
        else if (data_gnt)
            state_nxt = OWN_D;
        // a cancelled fetch neither clears nor advances the guard
        if (inst_gnt || !inst_req)
            starve_nxt = '0;
        else if (!cancel && data_gnt && starve_cnt != SMAX)
            starve_nxt = starve_cnt + 4'd1;
    end

    // SRAM drive follows the granted requester in the same cycle
    always_comb begin
        mem_en    = inst_gnt | data_gnt;
        mem_wen   = data_gnt ? data_wen : 4'h0;
        mem_addr  = data_gnt ? data_addr : inst_addr;
        mem_wdata = data_wdata;
    end

    // Responses: ack one cycle after grant; cancel drops a fetch response
    always_comb begin
        inst_ack   = (state == OWN_I) && !cancel;
        data_ack   = (state == OWN_D);
        // SRAM data is presented alongside ack, then the captured copy is held
        inst_rdata = inst_ack ? mem_rdata : inst_hold;
        data_rdata = data_ack ? mem_rdata : data_hold;
    end

    // Capture returned read data so each port's rdata holds until its next ack
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_hold <= '0;
            data_hold <= '0;
        end else begin
            if (inst_ack) inst_hold <= mem_rdata;
            if (data_ack) data_hold <= mem_rdata;
        end
    end

`ifdef ARB_STALL_CNT_EN
    logic [31:0] stall_q;

    // Count cycles where fetch wants the port but loses it (cancel cycles excluded)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            stall_q <= '0;
        else if (inst_req && !inst_gnt && !cancel)
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomised scoreboard bench for sram_port_arbiter. A negedge issue model
// predicts grants and pushes expected responses; a negedge monitor pops them
// when due and compares acks and read data. A behavioural SRAM backs the DUT.
module tb_sram_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SMAX   = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              inst_req, inst_gnt, inst_ack;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req, data_gnt, data_ack;
    logic [3:0]        data_wen;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata, data_rdata;
    logic              cancel;
    logic              mem_en;
    logic [3:0]        mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [31:0]       stall_cnt;

    sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_ack(data_ack),
        .data_rdata(data_rdata), .cancel(cancel),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Behavioural SRAM: 16 words, read returns the old contents
    logic [31:0] sram [16];
    logic [31:0] ref_mem [16];
    initial begin
        mem_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
    end
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= sram[mem_addr[5:2]];
            for (int b = 0; b < 4; b++)
                if (mem_wen[b]) sram[mem_addr[5:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t q[$];

    // Issue model: who should win this cycle, and what it must return next cycle
    int          waits = 0;
    logic [31:0] stall_exp = '0;
    always @(negedge clk) begin
        bit   win_i, win_d;
        rsp_t it;
        if (!resetn) begin
            waits     = 0;
            stall_exp = '0;
            chk("rst_gnt", {inst_gnt, data_gnt, mem_en, mem_wen}, 0);
            chk("rst_stall", stall_cnt, 0);
        end else begin
            win_i = inst_req && !cancel && (!data_req || waits == SMAX);
            win_d = !win_i && data_req;
            chk("inst_gnt", inst_gnt, win_i);
            chk("data_gnt", data_gnt, win_d);
            chk("mem_en", mem_en, win_i || win_d);
            chk("mem_wen", mem_wen, win_d ? data_wen : 4'h0);
            if (win_i || win_d) begin
                chk("mem_addr", mem_addr, win_d ? data_addr : inst_addr);
                it.is_d = win_d;
                it.data = ref_mem[win_d ? data_addr[5:2] : inst_addr[5:2]];
                it.due  = cyc + 1;
                q.push_back(it);
            end
            if (win_d && data_wen != 0) begin
                chk("mem_wdata", mem_wdata, data_wdata);
                for (int b = 0; b < 4; b++)
                    if (data_wen[b]) ref_mem[data_addr[5:2]][b*8 +: 8] = data_wdata[b*8 +: 8];
            end
`ifdef ARB_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, stall_exp);
            if (inst_req && !win_i && !cancel) stall_exp = stall_exp + 1;
`else
            chk("stall_cnt", stall_cnt, 0);
`endif
            if (win_i || !inst_req) waits = 0;
            else if (!cancel && win_d && waits < SMAX) waits++;
        end
    end

    // Monitor: pop responses when due and compare acks and rdata
    logic [31:0] last_i = '0, last_d = '0;
    always @(negedge clk) begin
        bit   ei, ed;
        rsp_t it;
        if (!resetn) begin
            q.delete();
            last_i = '0;
            last_d = '0;
            chk("rst_ack", {inst_ack, data_ack}, 0);
            chk("rst_rdata", {inst_rdata, data_rdata}, 0);
        end else begin
            ei = 0;
            ed = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                it = q.pop_front();
                if (it.is_d) begin
                    ed = 1;
                    last_d = it.data;
                end else if (!cancel) begin
                    ei = 1;
                    last_i = it.data;
                end
            end
            chk("inst_ack", inst_ack, ei);
            chk("data_ack", data_ack, ed);
            chk("inst_rdata", inst_rdata, last_i);
            chk("data_rdata", data_rdata, last_d);
        end
    end

    // Stimulus: modes 0 fetch-only, 1 both held, 2 directed contention, 3 random
    logic [31:0] fetch_pc = 32'hBFC0_0000;
    int          dop = 0;
    task automatic run_cycles(input int n, input int mode);
        bit gi, gd;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            gi = inst_gnt;
            gd = data_gnt;
            @(posedge clk);
            #1;
            if (!inst_req || gi) begin
                if (mode == 3) begin
                    inst_req  = ($urandom_range(0, 3) != 0);
                    inst_addr = $urandom;
                end else begin
                    inst_req  = 1'b1;
                    inst_addr = fetch_pc;
                    fetch_pc  = fetch_pc + 4;
                end
            end
            if (!data_req || gd) begin
                case (mode)
                    0: data_req = 1'b0;
                    1: begin
                        data_req  = 1'b1;
                        data_wen  = 4'h0;
                        data_addr = $urandom;
                    end
                    2: begin
                        if (dop < 2) begin
                            data_req   = 1'b1;
                            data_addr  = (dop == 0) ? 32'h1000 : 32'h1004;
                            data_wen   = (dop == 0) ? 4'h0 : 4'hF;
                            data_wdata = 32'hDEADBEEF;
                            dop++;
                        end else begin
                            data_req = 1'b0;
                        end
                    end
                    default: begin
                        data_req   = ($urandom_range(0, 3) != 0);
                        data_addr  = $urandom;
                        data_wen   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
                        data_wdata = $urandom;
                    end
                endcase
            end
            cancel = (mode == 3) ? ($urandom_range(0, 7) == 0) : 1'b0;
        end
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 0; inst_addr = '0;
        data_req = 0; data_wen = '0; data_addr = '0; data_wdata = '0;
        cancel = 0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        run_cycles(12, 0);
        run_cycles(8, 2);
        run_cycles(25, 1);

        // Cancel: fetch granted in N, cancel in N+1 with a data request
        @(posedge clk); #1;
        inst_req = 1; inst_addr = 32'h0000_0040; data_req = 0; cancel = 0;
        @(posedge clk); #1;
        inst_addr = 32'h0000_0044; cancel = 1;
        data_req = 1; data_wen = 0; data_addr = 32'h0000_0008;
        @(posedge clk); #1;
        cancel = 0; data_req = 0; inst_req = 0;

        run_cycles(400, 3);

        // Async reset while a data response is in flight
        @(posedge clk); #1;
        inst_req = 0; cancel = 0;
        data_req = 1; data_wen = 0; data_addr = 32'h0000_000C;
        @(posedge clk); #1;
        data_req = 0;
        #1 chk("pre_rst_data_ack", data_ack, 1);
        resetn = 1'b0;
        #1;
        chk("async_rst_drop", {data_ack, inst_ack, mem_en, inst_gnt, data_gnt}, 0);
        inst_req = 1; inst_addr = 32'h0000_0010;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        run_cycles(60, 3);

        @(posedge clk); #1;
        inst_req = 0; data_req = 0; cancel = 0;
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
